// File: rtl/mux_2.sv
// mux_2: registered two-input WIDTH-bit select stage with a valid flag and the select that produced o.
// Optional even-parity output o_par is built when MUX_2_PARITY_EN is defined.
module mux_2 #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] o,
   output logic             o_valid,
   output logic             sel_q
`ifdef MUX_2_PARITY_EN
  ,output logic             o_par
`endif
);

   logic [WIDTH-1:0] w_sel_data;
   logic [WIDTH-1:0] r_o;
   logic             r_valid;
   logic             r_sel;

   assign w_sel_data = sel ? b : a;

   // o_valid tracks en directly; o and sel_q only move on a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o     <= RESET_VAL;
         r_valid <= 1'b0;
         r_sel   <= 1'b0;
      end else begin
         r_valid <= en;
         if (en) begin
            r_o   <= w_sel_data;
            r_sel <= sel;
         end
      end
   end

   assign o       = r_o;
   assign o_valid = r_valid;
   assign sel_q   = r_sel;

`ifdef MUX_2_PARITY_EN
   localparam logic RESET_PAR = ^RESET_VAL;

   logic w_par;
   logic r_par;

   assign w_par = ^w_sel_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= RESET_PAR;
      end else if (en) begin
         r_par <= w_par;
      end
   end

   assign o_par = r_par;
`endif

`ifndef SYNTHESIS
   // An unknown select on a capture cycle has no defined result.
   a_sel_known : assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(sel));
`endif

endmodule

// File: tb/tb_mux_2.sv
// tb_mux_2: table-driven directed check of mux_2, plus hand-written asynchronous reset sequences.
// Builds with or without MUX_2_PARITY_EN; o_par is checked only when it exists.
module tb_mux_2;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        sel;
   logic        en;
   logic [15:0] o;
   logic        o_valid;
   logic        sel_q;
`ifdef MUX_2_PARITY_EN
   logic        o_par;
`endif

   int checks;
   int errors;

   mux_2 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .sel     (sel),
      .en      (en),
      .o       (o),
      .o_valid (o_valid),
      .sel_q   (sel_q)
`ifdef MUX_2_PARITY_EN
     ,.o_par   (o_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sel;
      logic        en;
      logic [15:0] exp_o;
      logic        exp_valid;
      logic        exp_sel_q;
      logic        exp_par;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [15:0] e_o, input logic e_v,
                                input logic e_s, input logic e_p);
      check({tag, ".o"}, o, e_o);
      check({tag, ".o_valid"}, {15'd0, o_valid}, {15'd0, e_v});
      check({tag, ".sel_q"}, {15'd0, sel_q}, {15'd0, e_s});
`ifdef MUX_2_PARITY_EN
      check({tag, ".o_par"}, {15'd0, o_par}, {15'd0, e_p});
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //            a         b         sel   en    exp_o     v     sq    par
      vecs[0]  = '{16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{16'h1234, 16'hABCD, 1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{16'h3333, 16'h4444, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{16'h5555, 16'h6666, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{16'h7777, 16'h8888, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{16'h9999, 16'hAAAA, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{16'h00AA, 16'h5500, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{16'h00AA, 16'h5500, 1'b1, 1'b1, 16'h5500, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{16'h00AA, 16'h5500, 1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{16'h0007, 16'h0000, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b1};
      vecs[17] = '{16'h0000, 16'h0003, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0};
      vecs[18] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0};

      // Load a non-reset value, then assert reset between edges: outputs clear without a clock.
      rst_n = 1'b1;
      a = 16'hFFFF; b = 16'hFFFF; sel = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1 check_outputs("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
      $display("reset asserted with a=b=FFFF sel=1 en=1: o=%h o_valid=%b sel_q=%b", o, o_valid, sel_q);
      // Reset held across an enabled edge still keeps the reset values.
      @(posedge clk); #1;
      check_outputs("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel; en = vecs[i].en;
         @(posedge clk); #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_valid,
                       vecs[i].exp_sel_q, vecs[i].exp_par);
         $display("vec%0d a=%h b=%h sel=%b en=%b -> o=%h o_valid=%b sel_q=%b", i,
                  vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].en, o, o_valid, sel_q);
      end

      // Back-to-back captures interrupted by a reset pulse between edges.
      a = 16'h00AA; b = 16'h5500; sel = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      check_outputs("b2b_pre", 16'h5500, 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_outputs("midrun_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      $display("mid-run reset pulse: o=%h o_valid=%b sel_q=%b", o, o_valid, sel_q);
      #1 rst_n = 1'b1;
      check_outputs("after_release", 16'h0000, 1'b0, 1'b0, 1'b0);
      // First capture after release lands on the next enabled edge.
      sel = 1'b0;
      @(posedge clk); #1;
      check_outputs("first_capture", 16'h00AA, 1'b1, 1'b0, 1'b0);
      $display("first capture after reset: o=%h o_valid=%b sel_q=%b", o, o_valid, sel_q);
      en = 1'b0;
      @(posedge clk); #1;
      check_outputs("final_hold", 16'h00AA, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
